// File: rtl/timer_mmio_responder.sv
// Memory-mapped timer: prescaled 32-bit counter with compare match, one-shot or
// auto-reload operation and a level interrupt, decoded in a 32-byte window.
module timer_mmio_responder #(
   parameter logic [31:0] BASE_ADDR = 32'h1001_0400
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_read_i,
   input  logic        mem_write_i,
   input  logic [31:0] address_i,
   input  logic [31:0] write_data_i,
   output logic [31:0] data_o,
   output logic        hit_o,
   output logic        irq_o
);

   typedef enum logic [2:0] {
      REG_CTRL     = 3'd0,
      REG_PRESCALE = 3'd1,
      REG_COMPARE  = 3'd2,
      REG_COUNT    = 3'd3,
      REG_STATUS   = 3'd4
   } reg_sel_e;

   reg_sel_e    sel;
   logic        enable;
   logic        auto_reload;
   logic        irq_en;
   logic [15:0] prescale;
   logic [15:0] pre_cnt;
   logic [31:0] compare;
   logic [31:0] count;
   logic        match_flag;

   logic        wr_en;
   logic        wr_ctrl;
   logic        wr_prescale;
   logic        wr_compare;
   logic        wr_count;
   logic        wr_status;
   logic        tick;
   logic        match;
   logic        unused_byte_lanes;

   assign sel               = reg_sel_e'(address_i[4:2]);
   assign unused_byte_lanes = ^address_i[1:0];

   assign hit_o       = (address_i[31:5] == BASE_ADDR[31:5]);
   assign wr_en       = mem_write_i && hit_o;
   assign wr_ctrl     = wr_en && (sel == REG_CTRL);
   assign wr_prescale = wr_en && (sel == REG_PRESCALE);
   assign wr_compare  = wr_en && (sel == REG_COMPARE);
   assign wr_count    = wr_en && (sel == REG_COUNT);
   assign wr_status   = wr_en && (sel == REG_STATUS);

   assign tick  = enable && (pre_cnt == prescale);
   assign match = tick && (count == compare);

   // Both operands are registers, so there is no path from the bus to the interrupt.
   assign irq_o = match_flag & irq_en;

   // Enabling from 0 needs no extra term: pre_cnt is already held at 0 while disabled.
   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pre_cnt <= '0;
      end else if (!enable || wr_prescale || tick) begin
         pre_cnt <= '0;
      end else begin
         pre_cnt <= pre_cnt + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         enable      <= 1'b0;
         auto_reload <= 1'b0;
         irq_en      <= 1'b0;
      end else if (wr_ctrl) begin
         enable      <= write_data_i[0];
         auto_reload <= write_data_i[1];
         irq_en      <= write_data_i[2];
      end else if (match && !auto_reload) begin
         enable <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prescale <= '0;
         compare  <= '0;
      end else begin
         if (wr_prescale) prescale <= write_data_i[15:0];
         if (wr_compare)  compare  <= write_data_i;
      end
   end

   // A bus write to COUNT overrides whatever the tick would have done.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (wr_count) begin
         count <= write_data_i;
      end else if (tick) begin
         if (!match) begin
            count <= count + 32'd1;
         end else if (auto_reload) begin
            count <= '0;
         end
      end
   end

   // A match on the same edge as a write-1-clear keeps the flag set.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         match_flag <= 1'b0;
      end else if (match) begin
         match_flag <= 1'b1;
      end else if (wr_status && write_data_i[0]) begin
         match_flag <= 1'b0;
      end
   end

   // NOTE: data_o gets its default before the case so no path can infer a latch.
   always_comb begin
      data_o = '0;
      if (mem_read_i && hit_o) begin
         case (sel)
            REG_CTRL:     data_o = {29'd0, irq_en, auto_reload, enable};
            REG_PRESCALE: data_o = {16'd0, prescale};
            REG_COMPARE:  data_o = compare;
            REG_COUNT:    data_o = count;
            REG_STATUS:   data_o = {31'd0, match_flag};
            default:      data_o = '0;
         endcase
      end
   end

endmodule

// File: doc/timer_mmio_responder.md
TIMER_MMIO_RESPONDER -- requirements
Module: timer_mmio_responder

Interface
REQ-001 Parameter BASE_ADDR, default 32'h1001_0400, base byte address of the 32-byte register window.
REQ-002 clk  input  1  rising-edge clock shared with the pipeline.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 mem_read_i  input  1  read request from the EX/MEM stage.
REQ-005 mem_write_i  input  1  write request from the EX/MEM stage.
REQ-006 address_i  input  32  byte address from the EX/MEM ALU result.
REQ-007 write_data_i  input  32  store data from the EX/MEM stage.
REQ-008 data_o  output  32  read data, combinational, sampled by the MEM/WB register.
REQ-009 hit_o  output  1  high when address_i[31:5] == BASE_ADDR[31:5]; the external read-data mux uses it to select this block over data memory.
REQ-010 irq_o  output  1  interrupt request, equal to match_flag AND irq_en.

Function
REQ-011 Register map (word offsets; address_i[1:0] is ignored):
- 0x00 CTRL: bit0 enable, bit1 auto_reload, bit2 irq_en; other bits read 0.
- 0x04 PRESCALE: bits[15:0]; other bits read 0.
- 0x08 COMPARE: 32 bits.
- 0x0C COUNT: 32 bits.
- 0x10 STATUS: bit0 match_flag; write 1 to clear.
- 0x14-0x1C: read 0; writes ignored.
REQ-012 Writes SHALL occur on the rising clk edge when mem_write_i && hit_o; writes without hit_o SHALL have no effect.
REQ-013 data_o SHALL be the addressed register when mem_read_i && hit_o, else 32'h0; reads SHALL have no side effects.
REQ-014 A simultaneous read and write to the same register SHALL return the pre-write value in that cycle.
REQ-015 Prescaler pre_cnt (16 bits) SHALL increment each cycle while enable=1.
REQ-016 When pre_cnt == PRESCALE, the block SHALL assert an internal tick and set pre_cnt to 0, so a tick occurs every PRESCALE+1 cycles.
REQ-017 While enable=0, pre_cnt SHALL be held at 0 and COUNT SHALL hold its value.
REQ-018 A write to PRESCALE, or a write to CTRL that sets enable from 0 to 1, SHALL clear pre_cnt to 0.
REQ-019 On a tick with COUNT != COMPARE, COUNT SHALL increment by 1 and wrap from 32'hFFFF_FFFF to 0.
REQ-020 On a tick with COUNT == COMPARE, the block SHALL set match_flag and then:
- if auto_reload=1, set COUNT to 0 and keep enable=1;
- if auto_reload=0, hold COUNT and clear enable (one-shot).
REQ-021 A software write to COUNT or CTRL in the same cycle as a tick SHALL take precedence over the tick's update of that register.
REQ-022 A write-1-clear of STATUS in the same cycle as a match SHALL leave match_flag = 1 (set wins).
REQ-023 irq_o SHALL be driven only from registered state, with no combinational path from the bus inputs.
REQ-024 hit_o SHALL be purely combinational from address_i, regardless of mem_read_i and mem_write_i.

Reset
REQ-025 On reset asserted, asynchronously, the block SHALL clear CTRL, PRESCALE, COMPARE, COUNT, pre_cnt and match_flag to 0.
REQ-026 During reset, irq_o SHALL be 0; data_o SHALL follow REQ-013.
REQ-027 Reset asserted mid-count SHALL abort counting immediately, with no tick on the release edge.
REQ-028 After reset deasserts, the block SHALL accept bus writes on the first clk edge.

Verification
REQ-029 Register access: write COMPARE=32'h0000_00AB, then read 0x08 -> data_o=32'h0000_00AB; read 0x14 -> 0; read with address outside the window -> hit_o=0, data_o=0.
REQ-030 Periodic mode: PRESCALE=2, COMPARE=3, CTRL=3'b011 -> a tick every 3 cycles; COUNT goes 0,1,2,3 then 0; match_flag sets on the 4th tick; the cycle repeats every 12 cycles.
REQ-031 One-shot and IRQ: PRESCALE=0, COMPARE=5, CTRL=3'b101 -> after 6 cycles match_flag=1, irq_o=1, COUNT holds 5, CTRL reads 3'b100; writing STATUS=1 -> irq_o=0 next cycle.
REQ-032 Collisions: a COUNT write of 32'h10 on the tick cycle -> COUNT=32'h10; a STATUS clear on the match cycle -> match_flag stays 1.
REQ-033 Wrap-around: COUNT=32'hFFFF_FFFF, COMPARE=32'h0000_0000, PRESCALE=0, enable=1 -> next tick COUNT=0, following tick match_flag=1.
REQ-034 Reset mid-operation: assert reset while running with COUNT=7 -> all registers read 0 and irq_o=0 immediately; no tick occurs after release.
